// File: rtl/fetch_queue.sv
// Decoupled fetch stage: owns the PC, keeps up to MAX_OUT requests in flight
// to instruction memory, and buffers returned instructions for decode.
module fetch_queue #(
    parameter int          WIDTH    = 16,
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int          INC      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             dec_valid,
    input  logic             dec_ready,
    output logic [WIDTH-1:0] dec_instr,
    output logic [WIDTH-1:0] dec_pc2,
    output logic             err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int SW = $clog2(DEPTH + MAX_OUT + 1) + 1;
    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_rsp_pc;
    logic [OW-1:0]    r_outst;
    logic [OW-1:0]    r_drop;
    logic [CW-1:0]    r_count;
    logic [AW-1:0]    r_rd;
    logic [AW-1:0]    r_wr;
    logic [WIDTH-1:0] r_instr [DEPTH];
    logic [WIDTH-1:0] r_pc2   [DEPTH];
    logic             r_err;

    logic             w_rsp_ok;
    logic             w_spur;
    logic             w_stale;
    logic             w_push;
    logic             w_pop;
    logic             w_fire;
    logic [SW-1:0]    w_fill;
    logic [OW-1:0]    w_outst_nx;

    // A response with nothing in flight is a protocol violation and is ignored.
    assign w_rsp_ok = imem_rvalid & (r_outst != '0);
    assign w_spur   = imem_rvalid & (r_outst == '0);
    assign w_stale  = w_rsp_ok & (r_drop != '0);
    assign w_push   = w_rsp_ok & ~w_stale & ~redirect;
    assign w_pop    = dec_valid & dec_ready & ~redirect;

    // Live in-flight requests already own a queue slot; a same-cycle pop is not credited.
    assign w_fill = SW'(r_count) + SW'(r_outst) - SW'(r_drop);

    assign imem_req = ~redirect & ~halt
                    & (r_outst < OW'(MAX_OUT))
                    & (w_fill < SW'(DEPTH));
    assign imem_addr = r_pc;
    assign w_fire    = imem_req & imem_gnt;

    assign w_outst_nx = r_outst + OW'(w_fire) - OW'(w_rsp_ok);

    assign dec_valid = (r_count != '0);
    assign dec_instr = r_instr[r_rd];
    assign dec_pc2   = r_pc2[r_rd];
    assign err       = r_err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc     <= RESET_PC;
            r_rsp_pc <= RESET_PC;
            r_outst  <= '0;
            r_drop   <= '0;
            r_count  <= '0;
            r_rd     <= '0;
            r_wr     <= '0;
            r_err    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_instr[i] <= '0;
                r_pc2[i]   <= '0;
            end
        end else begin
            r_outst <= w_outst_nx;
            if (w_spur) begin
                r_err <= 1'b1;
            end
            if (redirect) begin
                // Everything still in flight now belongs to the old path.
                r_pc     <= redirect_pc;
                r_rsp_pc <= redirect_pc;
                r_count  <= '0;
                r_rd     <= '0;
                r_wr     <= '0;
                r_drop   <= r_outst - OW'(w_rsp_ok);
            end else begin
                if (w_fire) begin
                    r_pc <= r_pc + INC_W;
                end
                if (w_stale) begin
                    r_drop <= r_drop - OW'(1);
                end
                if (w_push) begin
                    r_instr[r_wr] <= imem_rdata;
                    r_pc2[r_wr]   <= r_rsp_pc + INC_W;
                    r_wr          <= r_wr + AW'(1);
                    r_rsp_pc      <= r_rsp_pc + INC_W;
                end
                if (w_pop) begin
                    r_rd <= r_rd + AW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule
